// File: rtl/regfile_pkg.sv
// Shared constants and types for the one-hot register file and its select
// decoder.
//   DEF_NREGS  : register count (fixed by the 5-bit select space)
//   ADDR_W     : register address width
//   DEF_DATA_W : default register data width
//   addr_t     : register address / index type
//   data_t     : register data type at the default width
package regfile_pkg;

    localparam int DEF_NREGS  = 32;
    localparam int ADDR_W     = 5;
    localparam int DEF_DATA_W = 32;

    typedef logic [ADDR_W-1:0]     addr_t;
    typedef logic [DEF_DATA_W-1:0] data_t;

endpackage : regfile_pkg

// File: rtl/onehot_check.sv
// Combinational classifier for a write-enable vector.
//   vec       : NREGS-bit enable vector
//   is_onehot : 1 when exactly one bit of vec is set
//   index     : position of the set bit (meaningful only when is_onehot=1)
module onehot_check
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS
) (
    input  logic [NREGS-1:0] vec,
    output logic             is_onehot,
    output addr_t            index
);

    assign is_onehot = ($countones(vec) == 1);

    // OR together the positions of every set bit; for a legal one-hot vector
    // this is exactly the selected index, and no priority chain is needed.
    // NOTE: every output of an always_comb gets a default on entry, otherwise
    // paths that skip the assignment infer a latch.
    always_comb begin
        index = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (vec[i]) begin
                index = index | addr_t'(i);
            end
        end
    end

endmodule : onehot_check

// File: rtl/onehot_regfile.sv
// Register file written through a one-hot enable vector, with two registered
// read ports, a sticky illegal-enable flag and an accepted-write counter.
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr_valid              : write request qualifier
//   we_onehot [NREGS]     : one-hot register select for the write
//   wr_data   [DATA_W]    : write data
//   rd_addr_a/b [5]       : read addresses, sampled every rising edge
//   rd_data_a/b [DATA_W]  : read data, one cycle after the address (write-first)
//   err_clr               : clears err_sticky (a coincident illegal write wins)
//   err_sticky            : set by a qualified write whose enable is not one-hot
//   wr_count [8]          : number of accepted writes, wraps at 256
// Build option: define REGFILE_REG0_ZERO_EN to hard-wire register 0 to zero;
// writes to it are still accepted and counted, but their data is dropped.
module onehot_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [NREGS-1:0]  we_onehot,
    input  logic [DATA_W-1:0] wr_data,
    input  addr_t             rd_addr_a,
    input  addr_t             rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              err_clr,
    output logic              err_sticky,
    output logic [7:0]        wr_count
);

    logic              sel_onehot;
    addr_t             sel_index;
    logic              wr_accept;
    logic              wr_illegal;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
    logic              err_sticky_q, err_sticky_d;
    logic [7:0]        wr_count_q, wr_count_d;

    onehot_check #(
        .NREGS (NREGS)
    ) u_onehot_check (
        .vec       (we_onehot),
        .is_onehot (sel_onehot),
        .index     (sel_index)
    );

    assign wr_accept  = wr_valid & sel_onehot;
    assign wr_illegal = wr_valid & ~sel_onehot;

    always_comb begin
        regs_d = regs_q;
        if (wr_accept) begin
            regs_d[sel_index] = wr_data;
        end
`ifdef REGFILE_REG0_ZERO_EN
        regs_d[0] = '0;
`endif
        // Reading the next-state array gives write-first bypass for free: a
        // write landing this edge is already visible to the read mux.
        rd_data_a_d = regs_d[rd_addr_a];
        rd_data_b_d = regs_d[rd_addr_b];

        // Set has priority over clear so a coincident illegal write is kept.
        err_sticky_d = err_sticky_q;
        if (wr_illegal) begin
            err_sticky_d = 1'b1;
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
        end

        wr_count_d = wr_count_q;
        if (wr_accept) begin
            wr_count_d = wr_count_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    // NOTE: the storage array is reset along with the control flops because
    // reset must leave every register reading zero; this keeps it as flops
    // rather than an inferred RAM, which cannot be cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            err_sticky_q <= 1'b0;
            wr_count_q   <= '0;
        end else begin
            regs_q       <= regs_d;
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            err_sticky_q <= err_sticky_d;
            wr_count_q   <= wr_count_d;
        end
    end

    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign err_sticky = err_sticky_q;
    assign wr_count   = wr_count_q;

endmodule : onehot_regfile

// File: tb/tb_onehot_regfile.sv
// Self-checking bench for onehot_regfile: directed vectors with literal
// expectations, plus a behavioural model compared against the DUT on every
// falling clock edge. Honours REGFILE_REG0_ZERO_EN the same way as the design.
module tb_onehot_regfile;

    localparam int DW = 32;
    localparam int NR = 32;

`ifdef REGFILE_REG0_ZERO_EN
    localparam bit REG0_HARD = 1'b1;
`else
    localparam bit REG0_HARD = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          wr_valid;
    logic [NR-1:0] we_onehot;
    logic [DW-1:0] wr_data;
    logic [4:0]    rd_addr_a;
    logic [4:0]    rd_addr_b;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic          err_clr;
    logic          err_sticky;
    logic [7:0]    wr_count;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    onehot_regfile #(
        .DATA_W (DW),
        .NREGS  (NR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .we_onehot  (we_onehot),
        .wr_data    (wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
        .wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Registers as a plain array; each edge: count the enable bits, accept
    // exactly-one, reads see this edge's write (write-first).
    logic [DW-1:0] m_regs [NR];
    logic [DW-1:0] exp_a, exp_b;
    logic          exp_err;
    logic [7:0]    exp_cnt;
    int            m_ones, m_idx;
    bit            m_accept, m_store;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            exp_a   = '0;
            exp_b   = '0;
            exp_err = 1'b0;
            exp_cnt = '0;
        end else begin
            m_ones = $countones(we_onehot);
            m_idx  = 0;
            for (int i = 0; i < NR; i++) if (we_onehot[i]) m_idx = i;
            m_accept = wr_valid && (m_ones == 1);
            m_store  = m_accept && !(REG0_HARD && m_idx == 0);
            exp_a = (m_store && m_idx == int'(rd_addr_a)) ? wr_data : m_regs[rd_addr_a];
            exp_b = (m_store && m_idx == int'(rd_addr_b)) ? wr_data : m_regs[rd_addr_b];
            if (m_store) m_regs[m_idx] = wr_data;
            if (wr_valid && m_ones != 1) exp_err = 1'b1;
            else if (err_clr)            exp_err = 1'b0;
            if (m_accept) exp_cnt = exp_cnt + 8'd1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_rd_a", rd_data_a, exp_a);
            check("cmp_rd_b", rd_data_b, exp_b);
            check("cmp_err", err_sticky, exp_err);
            check("cmp_cnt", wr_count, exp_cnt);
        end
    end

    // ---------------- stimulus ----------------
    // Called at a falling edge: drive inputs, then run through the next rising
    // edge and stop at the following falling edge, where results are visible.
    task automatic step(input logic v, input logic [NR-1:0] we, input logic [DW-1:0] d,
                        input logic [4:0] ra, input logic [4:0] rb, input logic clr);
        wr_valid  = v;
        we_onehot = we;
        wr_data   = d;
        rd_addr_a = ra;
        rd_addr_b = rb;
        err_clr   = clr;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] we_v;
        logic [DW-1:0] d_v;
        logic [7:0]    b;

        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        we_onehot = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;

        check("reset_rd_a", rd_data_a, 0);
        check("reset_rd_b", rd_data_b, 0);
        check("reset_err", err_sticky, 0);
        check("reset_cnt", wr_count, 0);

        // Write presented while reset is held is discarded.
        step(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 5'd5, 5'd5, 1'b0);
        rst_n = 1'b1;
        step(1'b0, '0, '0, 5'd5, 5'd5, 1'b0);
        check("rst_edge_write_dropped", rd_data_a, 0);
        check("rst_edge_cnt", wr_count, 0);

        // Basic write to reg 3, read back on both ports next cycle.
        step(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 5'd0, 5'd1, 1'b0);
        step(1'b0, '0, '0, 5'd3, 5'd3, 1'b0);
        check("rd3_a", rd_data_a, 32'hDEAD_BEEF);
        check("rd3_b_same_addr", rd_data_b, 32'hDEAD_BEEF);
        check("cnt_after_one", wr_count, 1);

        // Two bits set: rejected, flag set, counter held.
        step(1'b1, 32'h0000_0011, 32'h0000_AAAA, 5'd0, 5'd4, 1'b0);
        check("illegal_err", err_sticky, 1);
        check("illegal_cnt", wr_count, 1);
        step(1'b0, '0, '0, 5'd0, 5'd4, 1'b0);
        check("illegal_reg0_kept", rd_data_a, 0);
        check("illegal_reg4_kept", rd_data_b, 0);
        check("err_stays", err_sticky, 1);
        step(1'b0, '0, '0, 5'd3, 5'd3, 1'b1);
        check("err_cleared", err_sticky, 0);

        // Zero bits set is also illegal; clear coinciding with illegal keeps it set.
        step(1'b1, '0, 32'h5555_5555, 5'd3, 5'd3, 1'b0);
        check("zero_hot_err", err_sticky, 1);
        step(1'b1, 32'h0000_0003, 32'h5555_5555, 5'd0, 5'd1, 1'b1);
        check("set_beats_clr", err_sticky, 1);
        step(1'b0, '0, '0, 5'd0, 5'd1, 1'b1);
        check("clr_again", err_sticky, 0);

        // wr_valid low: enable ignored entirely.
        step(1'b0, 32'h0000_0003, 32'h7777_7777, 5'd0, 5'd1, 1'b0);
        check("invalid_no_err", err_sticky, 0);
        check("invalid_no_cnt", wr_count, 1);

        // Same-edge bypass on port B.
        step(1'b1, 32'h8000_0000, 32'h0000_1234, 5'd3, 5'd31, 1'b0);
        check("bypass_b", rd_data_b, 32'h0000_1234);
        check("bypass_cnt", wr_count, 2);

        // Reg 0 write: counted either way, data kept only without the option.
        step(1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd31, 1'b0);
        check("reg0_cnt", wr_count, 3);
        step(1'b0, '0, '0, 5'd0, 5'd0, 1'b0);
`ifdef REGFILE_REG0_ZERO_EN
        check("reg0_read", rd_data_a, 0);
`else
        check("reg0_read", rd_data_a, 32'hFFFF_FFFF);
`endif

        // 253 more accepted writes bring the counter from 3 through 255 to 0.
        for (int i = 0; i < 253; i++) begin
            b    = 8'(i);
            we_v = 32'h1 << (i % 32);
            d_v  = {b, ~b, b ^ 8'h5A, 8'hC3};
            step(1'b1, we_v, d_v, 5'((i * 7) % 32), 5'(i % 32), 1'b0);
        end
        check("cnt_wrap", wr_count, 0);
        step(1'b1, 32'h0000_0040, 32'h0BAD_C0DE, 5'd6, 5'd6, 1'b0);
        check("cnt_after_wrap", wr_count, 1);
        check("bypass_a_reg6", rd_data_a, 32'h0BAD_C0DE);

        // Asynchronous reset between edges clears everything at once.
        step(1'b1, '0, '0, 5'd6, 5'd31, 1'b0);
        check("pre_rst_err", err_sticky, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rd_a", rd_data_a, 0);
        check("async_rd_b", rd_data_b, 0);
        check("async_err", err_sticky, 0);
        check("async_cnt", wr_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, '0, 5'd6, 5'd31, 1'b0);
        check("post_rst_reg6", rd_data_a, 0);
        check("post_rst_reg31", rd_data_b, 0);
        step(1'b1, 32'h0000_0400, 32'h0000_00A5, 5'd10, 5'd9, 1'b0);
        check("first_write_after_rst", rd_data_a, 32'h0000_00A5);
        check("first_cnt_after_rst", wr_count, 1);

        step(1'b0, '0, '0, 5'd0, 5'd0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_onehot_regfile

// File: doc/onehot_regfile.md
ONEHOT_REGFILE -- requirements
Module: onehot_regfile

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter NREGS, default 32, number of registers; fixed at 32 to match the 5-bit select space.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_valid  input  1  write request qualifier.
REQ-006 we_onehot  input  NREGS  one-hot write-enable vector from the 5-to-32 select decoder.
REQ-007 wr_data  input  DATA_W  write data.
REQ-008 rd_addr_a  input  5  read port A address.
REQ-009 rd_addr_b  input  5  read port B address.
REQ-010 rd_data_a  output  DATA_W  port A read data, registered.
REQ-011 rd_data_b  output  DATA_W  port B read data, registered.
REQ-012 err_clr  input  1  clears err_sticky.
REQ-013 err_sticky  output  1  latched illegal-enable flag.
REQ-014 wr_count  output  8  count of accepted writes.

Function
REQ-015 When wr_valid=1 and we_onehot has exactly one bit i set, reg[i] SHALL take wr_data at the rising edge.
REQ-016 When wr_valid=1 and we_onehot has zero bits or two or more bits set, no register SHALL change, err_sticky SHALL be set, and wr_count SHALL hold.
REQ-017 When wr_valid=0, we_onehot SHALL be ignored, and no write or error SHALL occur.
REQ-018 Each accepted write SHALL increment wr_count by 1, wrapping from 255 to 0.
REQ-019 Read latency SHALL be one cycle: rd_addr_x sampled at edge N, and rd_data_x SHALL be valid after edge N until edge N+1.
REQ-020 Write-first bypass: if an accepted write at edge N targets the register addressed by rd_addr_x at edge N, rd_data_x SHALL show the new wr_data.
REQ-021 Both read ports SHALL be independent; equal addresses SHALL return identical data.
REQ-022 err_sticky SHALL remain set until err_clr=1 at an edge; if err_clr and an illegal write coincide, set SHALL win.
REQ-023 No state machine beyond register storage, the error flag and the counter; no back-pressure, every cycle SHALL accept a write.

Reset
REQ-024 rst_n=0 SHALL immediately clear all registers, rd_data_a, rd_data_b, err_sticky and wr_count to 0.
REQ-025 A write presented at the edge coinciding with reset SHALL be discarded; the first write SHALL be accepted at the first edge with rst_n=1.

Configuration
REQ-026 Macro REGFILE_REG0_ZERO_EN defined: reg 0 SHALL always read 0 (bypass included); writes to reg 0 SHALL be accepted and counted but discarded.
REQ-027 Macro REGFILE_REG0_ZERO_EN undefined: reg 0 SHALL behave as an ordinary register.

Structure
REQ-028 Package regfile_pkg SHALL hold NREGS, ADDR_W=5, DATA_W defaults, plus the addr_t/data_t typedefs shared with the decoder.
REQ-029 One sub-module, onehot_check, SHALL be used: combinational, NREGS-bit input, outputs is_onehot and index (5 bits).

Verification
REQ-030 Reset, then write 0xDEADBEEF with we_onehot=0x0000_0008, then read addr 3 -> rd_data_a=0xDEADBEEF one cycle later, wr_count=1.
REQ-031 wr_valid=1, we_onehot=0x0000_0011 -> no register changed, err_sticky=1, wr_count unchanged; err_clr pulse -> err_sticky=0.
REQ-032 Same edge: write 0x1234 to reg 31 and rd_addr_b=31 -> rd_data_b=0x1234 next cycle (bypass).
REQ-033 Write 0xFFFF_FFFF to reg 0 -> reads 0 with REGFILE_REG0_ZERO_EN, reads 0xFFFF_FFFF without it; wr_count increments in both cases.
REQ-034 Perform 256 accepted writes -> wr_count wraps to 0; assert rst_n=0 mid-sequence -> all outputs 0 immediately.
